// File: rtl/instr_fetch.sv
// instr_fetch: three-state (IDLE/FETCH/ISSUE) instruction fetch unit that reads one
// word per request from instruction memory and decodes it into MIPS-style R-type fields.
// Latency: fields are valid the cycle after imem_ack. Throughput is one instruction per
// 2 cycles. stall freezes ISSUE, and a memory that never acks holds the block in FETCH.
//
// Ports
//   clk, rst                 single clock, asynchronous active-high reset
//   start / stop / stall     control: start honoured in IDLE, stop honoured on leaving ISSUE
//   imem_req / imem_addr     read request to instruction memory (address = pc)
//   imem_ack / imem_rdata    read data valid strobe and instruction word
//   opCode..funct            combinational decode of the instruction register
//   instr_valid, pc, busy    status
//   timeout_err              sticky fetch-timeout flag
//
// Build option: define FETCH_TIMEOUT_EN to abandon a fetch after TIMEOUT_CYCLES
// un-acked FETCH cycles. In that case pc is left unchanged and timeout_err is raised.
// Without the macro, FETCH waits forever and timeout_err is tied low.

module instr_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  opCode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // A zero or negative limit would make the timeout compare meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic          wait_expired;

  // wait_cnt_q counts FETCH cycles that already went by without ack, so the
  // TIMEOUT_CYCLES-th un-acked FETCH cycle is the one that sees TIMEOUT_CYCLES-1.
  assign wait_expired = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Held at zero outside FETCH, which makes it start from zero on every entry.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == FETCH && !imem_ack) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Next-state logic for the FSM, pc and instruction register.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
`ifdef FETCH_TIMEOUT_EN
        end else if (wait_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
`endif
        end
      end
      ISSUE: begin
        // stall has priority over stop: nothing moves until stall drops.
        if (!stall) begin
          pc_d    = pc_q + 32'd4;   // wraps modulo 2^32
          state_d = stop ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs depend only on registered state, so reset clears them immediately.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign pc          = pc_q;

  // The fields always reflect IR. instr_valid is what qualifies them.
  assign opCode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test of instr_fetch with hand-computed expected values.
// The main instance uses the default RESET_PC. A second instance starts at 32'hFFFF_FFFC
// to exercise pc wrap-around.

module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst, start, stop, stall, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, busy, timeout_err;
  logic [31:0] imem_addr, pc;
  logic [5:0]  opCode, funct;
  logic [4:0]  rs, rt, rd, shamt;

  // wrap instance
  logic        w_rst, w_start, w_stop, w_stall, w_ack;
  logic [31:0] w_rdata;
  logic        w_req, w_valid, w_busy, w_err;
  logic [31:0] w_addr, w_pc;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opCode(opCode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .timeout_err(timeout_err)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .start(w_start), .stop(w_stop), .stall(w_stall),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .opCode(w_op), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .funct(w_funct),
    .instr_valid(w_valid), .pc(w_pc), .busy(w_busy), .timeout_err(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    w_rst = 1'b1; w_start = 1'b0; w_stop = 1'b0; w_stall = 1'b0; w_ack = 1'b0; w_rdata = '0;

    // ---------------- reset state ----------------
    tick();
    chk("rst_req",   imem_req,    0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy",  busy,        0);
    chk("rst_pc",    pc,          32'h0);
    chk("rst_op",    opCode,      0);
    chk("rst_funct", funct,       0);
    chk("rst_err",   timeout_err, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // ---------------- start -> FETCH at RESET_PC ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f0_req",  imem_req,  1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_busy", busy,      1);

    // ---------------- asynchronous reset mid-FETCH ----------------
    #3 rst = 1'b1;
    #1;
    chk("arst_req",  imem_req, 0);
    chk("arst_busy", busy,     0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle_req", imem_req, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req2", imem_req,  1);

`ifdef FETCH_TIMEOUT_EN
    // ---------------- fetch timeout ----------------
    begin
      int n_req = 1;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (!imem_req) break;
        n_req++;
      end
      chk("to_cycles", n_req,       16);
      chk("to_err",    timeout_err, 1);
      chk("to_busy",   busy,        0);
      chk("to_pc",     pc,          32'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("to_err_clr", timeout_err, 0);
      chk("to_refetch", imem_req,    1);
    end
`else
    // ---------------- no timeout: waits indefinitely ----------------
    for (int i = 0; i < 20; i++) tick();
    chk("nto_req",  imem_req,    1);
    chk("nto_err",  timeout_err, 0);
    chk("nto_addr", imem_addr,   32'h0);
`endif

    // ---------------- zero-wait fetch of 32'h012A4020 ----------------
    stop = 1'b1;                     // stop in FETCH must be ignored
    tick();
    stop = 1'b0;
    chk("stop_in_fetch", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'h012A_4020;
    tick();
    imem_ack = 1'b0;
    chk("i0_valid", instr_valid, 1);
    chk("i0_op",    opCode,      6'd0);
    chk("i0_rs",    rs,          5'd9);
    chk("i0_rt",    rt,          5'd10);
    chk("i0_rd",    rd,          5'd8);
    chk("i0_shamt", shamt,       5'd0);
    chk("i0_funct", funct,       6'h20);
    chk("i0_pc",    pc,          32'h0);
    tick();
    chk("i1_req",   imem_req,    1);
    chk("i1_addr",  imem_addr,   32'h4);
    chk("i1_valid", instr_valid, 0);
    chk("i1_hold_rs", rs,        5'd9);

    // ---------------- stall for 3 cycles: lw 32'h8C430004 ----------------
    imem_ack = 1'b1; imem_rdata = 32'h8C43_0004;
    tick();
    chk("s_op",  opCode, 6'h23);
    chk("s_rs",  rs,     5'd2);
    chk("s_rt",  rt,     5'd3);
    chk("s_fn",  funct,  6'd4);
    stall = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;      // ack outside FETCH must be ignored
    start = 1'b1;                    // start outside IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_valid", instr_valid, 1);
      chk("s_pc",    pc,          32'h4);
      chk("s_op_h",  opCode,      6'h23);
      chk("s_req",   imem_req,    0);
    end
    imem_ack = 1'b0; start = 1'b0; stall = 1'b0;
    tick();
    chk("s_next_req",  imem_req,  1);
    chk("s_next_addr", imem_addr, 32'h8);

    // ---------------- stop + stall, then stall drops ----------------
    imem_ack = 1'b1; imem_rdata = 32'h2008_FFFF;
    tick();
    imem_ack = 1'b0;
    stop = 1'b1; stall = 1'b1;
    tick();
    chk("ss_valid", instr_valid, 1);
    chk("ss_busy",  busy,        1);
    chk("ss_pc",    pc,          32'h8);
    stall = 1'b0;
    tick();
    stop = 1'b0;
    chk("ss_busy0", busy,        0);
    chk("ss_req0",  imem_req,    0);
    chk("ss_pc12",  pc,          32'hC);
    chk("ss_valid0", instr_valid, 0);
    tick();
    chk("ss_stay_idle", busy, 0);

    // ---------------- wrap instance ----------------
    w_rst = 1'b0;
    tick();
    chk("w_rst_pc", w_pc, 32'hFFFF_FFFC);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h0000_0000;
    tick();
    w_ack = 1'b0;
    chk("w_valid", w_valid, 1);
    tick();
    chk("w_req1",  w_req,  1);
    chk("w_addr1", w_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so a broken DUT can never hang the run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
